riscv_irq_ctrl: RTL and testbench
=================================

// Module: riscv_irq_ctrl
// PURPOSE
//  Interrupt controller directly upstream of riscv_core. Feeds the core's irq_req_i and consumes its irq_ret_o.
//  Synchronises N_IRQ external sources, latches them as pending, masks them with the core's enable vector,
//  and arbitrates by fixed priority. Holds one request until the core signals return from the handler.
// PARAMETERS
//  N_IRQ      16    number of interrupt sources, 1..32
//  EDGE_SENS  '1    per-source bit: 1 = rising-edge triggered, 0 = level triggered
//  ID_W       (local) = N_IRQ>1 ? $clog2(N_IRQ) : 1
// PORTS
//  clk_i          in   1       clock; all flops on rising edge
//  rst_i          in   1       reset, asynchronous, active-low
//  irq_src_i      in   N_IRQ   raw asynchronous interrupt sources
//  irq_en_i       in   N_IRQ   per-source enable (mie) from the core
//  irq_ret_i      in   1       1-cycle pulse from core (irq_ret_o) at handler return
//  irq_req_o      out  1       request to core irq_req_i; level, held until irq_ret_i
//  irq_id_o       out  ID_W    index of granted source; valid while irq_req_o=1
//  irq_pending_o  out  N_IRQ   pending vector (mip readback), unmasked
// BEHAVIOUR
//  Reset (rst_i=0, async): irq_req_o=0, irq_id_o=0, irq_pending_o=0, sync/prev flops=0, FSM=IDLE.
//  Input path: 2-flop synchroniser per source (s1,s2), then prev<=s2; rise = s2 & ~prev.
//   - Edge source: pending set on rise; cleared on grant of that source.
//   - Level source: pending <= s2 each cycle; never cleared by grant.
//   - Set and clear in the same cycle: set wins (pending stays 1).
//   - prev resets to 0: a source high at reset release is seen as a rising edge.
//  Arbitration: cand = pending & irq_en_i; the lowest set index wins.
//  FSM:
//   IDLE   : cand!=0 -> ACTIVE; irq_id_o<=winner, irq_req_o<=1, clear pending[winner] if edge source.
//   ACTIVE : irq_req_o=1, irq_id_o stable; irq_ret_i=1 -> COOL, irq_req_o<=0.
//            Changes to irq_en_i or pending do not affect the held request.
//   COOL   : one cycle unconditionally -> IDLE. Lets level sources deassert before re-arbitration.
//  irq_ret_i in IDLE or COOL is ignored. irq_id_o holds its last value after return.
//  Latency: source high sampled at edge k -> pending visible after edge k+2, irq_req_o=1 after edge k+3.
//  irq_ret_i sampled at edge r -> irq_req_o=0 after r; the earliest next grant is after edge r+2.
//  A new edge on the source under service sets pending again; it is served after return.
//  Only one request is outstanding; there is no nesting or preemption in this block.
// TESTING
//  1 Edge on src[3], en=all 1 -> req=1, id=3 after edge 4; pending[3] clears at grant; ret -> req 0, no re-req.
//  2 src[5],src[2] rise together -> id=2 granted; ret at r -> id=5, req=1 after edge r+2.
//  3 en[7]=0, edge src[7] -> pending[7]=1, req stays 0; set en[7]=1 -> req=1, id=7 one edge later.
//  4 Level src[1] (EDGE_SENS[1]=0) held high -> re-requested after each ret+COOL; dropped before ret -> none.
//  5 src[3] pulses again while id=3 ACTIVE -> pending[3]=1; after ret, id=3 granted again at r+2.
//  6 rst_i=0 while ACTIVE -> req, id, pending =0 immediately; src[0] held high at release -> req after edge 4.

Source files
------------

// File: rtl/riscv_irq_ctrl_if.sv
// Interrupt request bus between riscv_irq_ctrl and the core (plus the raw
// source lines feeding the controller). The controller uses the slave view;
// the core / environment side uses the master view.
interface riscv_irq_ctrl_if #(
   parameter int N_IRQ = 16
);
   localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   logic [N_IRQ-1:0] irq_src_i;
   logic [N_IRQ-1:0] irq_en_i;
   logic             irq_ret_i;
   logic             irq_req_o;
   logic [ID_W-1:0]  irq_id_o;
   logic [N_IRQ-1:0] irq_pending_o;

   modport slave (
      input  irq_src_i, irq_en_i, irq_ret_i,
      output irq_req_o, irq_id_o, irq_pending_o
   );

   modport master (
      output irq_src_i, irq_en_i, irq_ret_i,
      input  irq_req_o, irq_id_o, irq_pending_o
   );
endinterface

// File: rtl/riscv_irq_ctrl.sv
// Interrupt controller in front of riscv_core: synchronises the raw sources,
// latches them as pending, masks with the core's enable vector and grants the
// lowest enabled index. One request is held until the core returns.
//
// state  | meaning
// IDLE   | no request outstanding; grant lowest enabled pending source
// ACTIVE | request held to the core; id frozen until irq_ret_i
// COOL   | one cycle after return so level sources can drop before re-arbitration
module riscv_irq_ctrl #(
   parameter int               N_IRQ     = 16,
   parameter logic [N_IRQ-1:0] EDGE_SENS = '1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   riscv_irq_ctrl_if.slave   bus
);
   localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, COOL} state_t;

   state_t           state;
   logic [N_IRQ-1:0] sync_s1;
   logic [N_IRQ-1:0] sync_s2;
   logic [N_IRQ-1:0] src_prev;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] cand;
   logic [N_IRQ-1:0] grant_mask;
   logic [N_IRQ-1:0] pending_nxt;
   logic [ID_W-1:0]  winner;
   logic             cand_any;
   logic             grant;
   logic             req_q;
   logic [ID_W-1:0]  id_q;

   // Two-flop synchroniser plus a delayed copy for edge detection. prev
   // resets low so a source already high at reset release counts as an edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_s1  <= '0;
         sync_s2  <= '0;
         src_prev <= '0;
      end else begin
         sync_s1  <= bus.irq_src_i;
         sync_s2  <= sync_s1;
         src_prev <= sync_s2;
      end
   end

   // Fixed priority: scan downward so the lowest set index is the last write.
   always_comb begin
      rise     = sync_s2 & ~src_prev;
      cand     = pending & bus.irq_en_i;
      winner   = '0;
      cand_any = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            winner   = ID_W'(i);
            cand_any = 1'b1;
         end
      end
      grant       = (state == IDLE) && cand_any;
      grant_mask  = grant ? (N_IRQ'(1) << winner) : '0;
      // Edge sources: set on rise, cleared on grant, set wins the tie.
      // Level sources simply follow the synchronised input.
      pending_nxt = (EDGE_SENS & ((pending & ~grant_mask) | rise))
                  | (~EDGE_SENS & sync_s2);
   end

   // Pending register update.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // Request sequencing with registered req/id outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         req_q <= 1'b0;
         id_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cand_any) begin
                  state <= ACTIVE;
                  req_q <= 1'b1;
                  id_q  <= winner;
               end
            end
            ACTIVE: begin
               if (bus.irq_ret_i) begin
                  state <= COOL;
                  req_q <= 1'b0;
               end
            end
            COOL: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.irq_req_o     = req_q;
   assign bus.irq_id_o      = id_q;
   assign bus.irq_pending_o = pending;
endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Bench for riscv_irq_ctrl: directed scenarios with fixed expected values,
// then randomized traffic, with every cycle compared against a behavioural
// model built from the source-sample history.
module tb_riscv_irq_ctrl;
   localparam int          N    = 16;
   localparam logic [15:0] EDGE = 16'hFDFD;   // sources 1 and 9 are level

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   riscv_irq_ctrl_if #(.N_IRQ(N)) bus ();

   riscv_irq_ctrl #(.N_IRQ(N), .EDGE_SENS(EDGE)) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sync'd value = source sampled two edges ago, its
   // predecessor three edges ago; one held request, one-cycle cool-down.
   logic [15:0] hist[$];
   logic [15:0] m_pend;
   logic        m_req;
   logic [3:0]  m_id;
   logic        m_cool;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hist   = '{16'h0, 16'h0, 16'h0};
         m_pend = '0;
         m_req  = 1'b0;
         m_id   = '0;
         m_cool = 1'b0;
      end else begin
         logic [15:0] s_now, s_old, cand, lsb, clr;
         int          gid;
         s_now = hist[1];
         s_old = hist[2];
         cand  = m_pend & bus.irq_en_i;
         clr   = '0;
         if (m_cool) begin
            m_cool = 1'b0;
         end else if (m_req) begin
            if (bus.irq_ret_i) begin
               m_req  = 1'b0;
               m_cool = 1'b1;
            end
         end else if (cand != 0) begin
            lsb   = cand & (~cand + 16'd1);
            gid   = $clog2(lsb);
            m_req = 1'b1;
            m_id  = 4'(gid);
            clr   = lsb & EDGE;
         end
         m_pend = (EDGE & ((m_pend & ~clr) | (s_now & ~s_old))) | (~EDGE & s_now);
         hist.push_front(bus.irq_src_i);
         void'(hist.pop_back());
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      if (rst_i) begin
         chk("model_req", 32'(bus.irq_req_o), 32'(m_req));
         chk("model_id", 32'(bus.irq_id_o), 32'(m_id));
         chk("model_pend", 32'(bus.irq_pending_o), 32'(m_pend));
      end
   end

   task automatic do_reset(input logic [15:0] src);
      @(negedge clk_i);
      rst_i         = 1'b0;
      bus.irq_src_i = src;
      bus.irq_en_i  = '1;
      bus.irq_ret_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic pulse_ret();
      bus.irq_ret_i = 1'b1;
      @(negedge clk_i);
      bus.irq_ret_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.irq_src_i = '0;
      bus.irq_en_i  = '1;
      bus.irq_ret_i = 1'b0;

      // 1: single edge source
      do_reset(16'h0);
      chk("rst_req", 32'(bus.irq_req_o), 32'h0);
      chk("rst_pend", 32'(bus.irq_pending_o), 32'h0);
      bus.irq_src_i = 16'h0008;
      repeat (3) @(negedge clk_i);
      chk("t1_req_e3", 32'(bus.irq_req_o), 32'h0);
      chk("t1_pend_e3", 32'(bus.irq_pending_o), 32'h0008);
      @(negedge clk_i);
      chk("t1_req_e4", 32'(bus.irq_req_o), 32'h1);
      chk("t1_id_e4", 32'(bus.irq_id_o), 32'h3);
      chk("t1_pend_clr", 32'(bus.irq_pending_o), 32'h0);
      bus.irq_src_i = 16'h0;
      repeat (2) @(negedge clk_i);
      pulse_ret();
      chk("t1_req_ret", 32'(bus.irq_req_o), 32'h0);
      repeat (3) @(negedge clk_i);
      chk("t1_no_rereq", 32'(bus.irq_req_o), 32'h0);
      chk("t1_id_hold", 32'(bus.irq_id_o), 32'h3);

      // 2: simultaneous edges, priority and re-grant after cool-down
      do_reset(16'h0);
      bus.irq_src_i = 16'h0024;
      repeat (4) @(negedge clk_i);
      chk("t2_id", 32'(bus.irq_id_o), 32'h2);
      chk("t2_pend", 32'(bus.irq_pending_o), 32'h0020);
      bus.irq_src_i = 16'h0;
      pulse_ret();
      chk("t2_req_r", 32'(bus.irq_req_o), 32'h0);
      @(negedge clk_i);
      chk("t2_req_r1", 32'(bus.irq_req_o), 32'h0);
      @(negedge clk_i);
      chk("t2_req_r2", 32'(bus.irq_req_o), 32'h1);
      chk("t2_id_r2", 32'(bus.irq_id_o), 32'h5);
      pulse_ret();

      // 3: masked source waits for its enable
      do_reset(16'h0);
      bus.irq_en_i  = 16'hFF7F;
      bus.irq_src_i = 16'h0080;
      repeat (6) @(negedge clk_i);
      chk("t3_req_masked", 32'(bus.irq_req_o), 32'h0);
      chk("t3_pend", 32'(bus.irq_pending_o), 32'h0080);
      bus.irq_en_i = '1;
      @(negedge clk_i);
      chk("t3_req_en", 32'(bus.irq_req_o), 32'h1);
      chk("t3_id_en", 32'(bus.irq_id_o), 32'h7);
      bus.irq_src_i = 16'h0;
      pulse_ret();

      // 4: level source re-requests until it drops
      do_reset(16'h0);
      bus.irq_src_i = 16'h0002;
      repeat (4) @(negedge clk_i);
      chk("t4_req", 32'(bus.irq_req_o), 32'h1);
      chk("t4_id", 32'(bus.irq_id_o), 32'h1);
      repeat (2) @(negedge clk_i);
      pulse_ret();
      repeat (2) @(negedge clk_i);
      chk("t4_rereq", 32'(bus.irq_req_o), 32'h1);
      chk("t4_reid", 32'(bus.irq_id_o), 32'h1);
      bus.irq_src_i = 16'h0;
      repeat (4) @(negedge clk_i);
      pulse_ret();
      repeat (3) @(negedge clk_i);
      chk("t4_dropped", 32'(bus.irq_req_o), 32'h0);

      // 5: new edge on the source under service
      do_reset(16'h0);
      bus.irq_src_i = 16'h0008;
      repeat (4) @(negedge clk_i);
      chk("t5_id", 32'(bus.irq_id_o), 32'h3);
      bus.irq_src_i = 16'h0;
      repeat (2) @(negedge clk_i);
      bus.irq_src_i = 16'h0048;
      @(negedge clk_i);
      bus.irq_src_i = 16'h0;
      repeat (3) @(negedge clk_i);
      chk("t5_pend_again", 32'(bus.irq_pending_o), 32'h0048);
      chk("t5_req_held", 32'(bus.irq_req_o), 32'h1);
      pulse_ret();
      repeat (2) @(negedge clk_i);
      chk("t5_req_again", 32'(bus.irq_req_o), 32'h1);
      chk("t5_id_again", 32'(bus.irq_id_o), 32'h3);
      chk("t5_pend_left", 32'(bus.irq_pending_o), 32'h0040);

      // 6: asynchronous reset while active, source high at release
      bus.irq_src_i = 16'h0001;
      #2;
      rst_i = 1'b0;
      #1;
      chk("t6_req_rst", 32'(bus.irq_req_o), 32'h0);
      chk("t6_id_rst", 32'(bus.irq_id_o), 32'h0);
      chk("t6_pend_rst", 32'(bus.irq_pending_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("t6_req_e3", 32'(bus.irq_req_o), 32'h0);
      @(negedge clk_i);
      chk("t6_req_e4", 32'(bus.irq_req_o), 32'h1);
      chk("t6_id_e4", 32'(bus.irq_id_o), 32'h0);
      bus.irq_src_i = 16'h0;
      pulse_ret();

      // Randomized traffic against the model
      do_reset(16'h0);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         bus.irq_src_i = bus.irq_src_i ^ 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0)
            bus.irq_en_i = 16'($urandom | $urandom);
         bus.irq_ret_i = (bus.irq_req_o && ($urandom_range(0, 3) == 0))
                      || ($urandom_range(0, 31) == 0);
      end
      bus.irq_ret_i = 1'b0;
      @(negedge clk_i);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
